// File: rtl/caliptra_imem_arb_pkg.sv
// caliptra_imem_arb_pkg: shared types for the IMEM write-buffer arbiter.
// The entry struct is sized to the default IMEM geometry.
package caliptra_imem_arb_pkg;
  localparam int IMEM_ADDR_W = 13;
  localparam int IMEM_DATA_W = 64;
  typedef enum logic {LOCK_OPEN, LOCK_LOCKED} lock_state_e;
  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] addr;
    logic [IMEM_DATA_W-1:0] data;
  } imem_wr_t;
endpackage

// File: rtl/caliptra_imem_wr_fifo.sv
// caliptra_imem_wr_fifo: external write buffer; exposes per-entry valid/address
// so the arbiter can detect read-after-write hazards.
module caliptra_imem_wr_fifo
  import caliptra_imem_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 13
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  imem_wr_t                         push_entry,
  input  logic                             pop,
  output imem_wr_t                         head,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]     addr
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  imem_wr_t [DEPTH-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    head = mem_q[rd_ptr_q];
    count = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (PW+1)'(PW'(PW'(i) - rd_ptr_q)) < count_q;
      addr[i] = ADDR_W'(mem_q[i].addr);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // Storage carries no reset; validity comes solely from the pointers.
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/caliptra_imem_arb.sv
// caliptra_imem_arb: arbitrates a single-port IMEM between core fetches and a
// buffered external loader, with starvation relief, hazard ordering and a lock.
module caliptra_imem_arb
  import caliptra_imem_arb_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              cptra_rst_b,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_full,
  input  logic              ext_lock,
  output logic              ext_drop_err,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  lock_state_e lock_q, lock_d;
  logic [SW-1:0] starve_q, starve_d;
  logic rvalid_q, rvalid_d, drop_q, drop_d;
  logic [CW:0] count;
  logic [FIFO_DEPTH-1:0] valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] entry_addr;
  imem_wr_t head, push_entry;
  logic nonempty, full, hazard, starve, ext_win, gnt, push;
  caliptra_imem_wr_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk), .rst_n(cptra_rst_b), .push(push), .push_entry(push_entry),
    .pop(ext_win), .head(head), .count(count), .valid(valid), .addr(entry_addr)
  );
  always_comb begin
    nonempty = count != '0;
    full = count == (CW+1)'(FIFO_DEPTH);
    hazard = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) hazard |= valid[i] && entry_addr[i] == core_addr;
    starve = starve_q == SW'(STARVE_LIMIT);
    // Combinational outputs are gated so everything reads 0 while in reset.
    ext_win = cptra_rst_b && nonempty && (!core_req || starve || full || hazard);
    gnt = cptra_rst_b && core_req && !ext_win;
    push = ext_we && !full && lock_q == LOCK_OPEN;
    push_entry = '{addr: IMEM_ADDR_W'(ext_addr), data: IMEM_DATA_W'(ext_wdata)};
    lock_d = ext_lock ? LOCK_LOCKED : lock_q;
    drop_d = drop_q || (ext_we && !push);
    rvalid_d = gnt;
    starve_d = (ext_win || !nonempty) ? '0 : (gnt && !starve) ? starve_q + SW'(1) : starve_q;
    core_gnt = gnt;
    core_rvalid = rvalid_q;
    core_rdata = sram_rdata;
    ext_full = full;
    ext_drop_err = drop_q;
    sram_cs = ext_win || gnt;
    sram_we = ext_win;
    sram_addr = ext_win ? ADDR_W'(head.addr) : gnt ? core_addr : '0;
    sram_wdata = ext_win ? DATA_W'(head.data) : '0;
  end
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      lock_q <= LOCK_OPEN;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_caliptra_imem_arb.sv
// tb_caliptra_imem_arb: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the arbitration rules and an SRAM image.
module tb_caliptra_imem_arb;
  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } ent_t;
  logic clk = 1'b0;
  logic cptra_rst_b, core_req, ext_we, ext_lock;
  logic [12:0] core_addr, ext_addr, sram_addr;
  logic [63:0] ext_wdata, core_rdata, sram_wdata, sram_rdata;
  logic core_gnt, core_rvalid, ext_full, ext_drop_err, sram_cs, sram_we;
  logic [63:0] sram_mem [8192];
  logic [63:0] ref_mem [8192];
  ent_t q[$];
  int starve_n, checks, failures;
  logic locked, drop, rv_exp, last_gnt, last_we, last_full;
  logic [63:0] rd_exp;
  logic [9:0] pat;

  caliptra_imem_arb dut (
    .clk(clk), .cptra_rst_b(cptra_rst_b), .core_req(core_req), .core_addr(core_addr),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_full(ext_full),
    .ext_lock(ext_lock), .ext_drop_err(ext_drop_err), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else sram_rdata <= sram_mem[sram_addr];
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    starve_n = 0;
    locked = 1'b0;
    drop = 1'b0;
    rv_exp = 1'b0;
  endtask

  task automatic step();
    int n;
    logic full, haz, win, gnt, accept;
    #1;
    n = q.size();
    full = n == 4;
    haz = 1'b0;
    foreach (q[i]) if (q[i].addr == core_addr) haz = 1'b1;
    win = n > 0 && (!core_req || starve_n == 8 || full || haz);
    gnt = core_req && !win;
    chk("core_gnt", 64'(core_gnt), 64'(gnt));
    chk("sram_cs", 64'(sram_cs), 64'(win || gnt));
    chk("sram_we", 64'(sram_we), 64'(win));
    chk("sram_addr", 64'(sram_addr), win ? 64'(q[0].addr) : gnt ? 64'(core_addr) : 64'd0);
    chk("sram_wdata", sram_wdata, win ? q[0].data : 64'd0);
    chk("ext_full", 64'(ext_full), 64'(full));
    chk("ext_drop_err", 64'(ext_drop_err), 64'(drop));
    chk("core_rvalid", 64'(core_rvalid), 64'(rv_exp));
    if (rv_exp) chk("core_rdata", core_rdata, rd_exp);
    last_gnt = core_gnt;
    last_we = sram_we;
    last_full = ext_full;
    @(posedge clk);
    if (win) begin
      ref_mem[q[0].addr] = q[0].data;
      void'(q.pop_front());
    end
    accept = ext_we && !full && !locked;
    if (accept) q.push_back('{ext_addr, ext_wdata});
    if (ext_we && !accept) drop = 1'b1;
    if (ext_lock) locked = 1'b1;
    starve_n = (win || n == 0) ? 0 : (gnt && starve_n < 8) ? starve_n + 1 : starve_n;
    rv_exp = gnt;
    if (gnt) rd_exp = ref_mem[core_addr];
    @(negedge clk);
  endtask

  task automatic do_reset();
    cptra_rst_b = 1'b0;
    #1;
    chk("rst_core_gnt", 64'(core_gnt), 64'd0);
    chk("rst_sram_cs", 64'(sram_cs), 64'd0);
    chk("rst_sram_we", 64'(sram_we), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_sram_wdata", sram_wdata, 64'd0);
    chk("rst_ext_full", 64'(ext_full), 64'd0);
    chk("rst_drop_err", 64'(ext_drop_err), 64'd0);
    chk("rst_rvalid", 64'(core_rvalid), 64'd0);
    chk("rst_rdata_pass", core_rdata, sram_rdata);
    @(posedge clk);
    @(negedge clk);
    cptra_rst_b = 1'b1;
    model_clear();
  endtask

  task automatic idle();
    core_req = 1'b0;
    ext_we = 1'b0;
    ext_lock = 1'b0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [63:0] d);
    ext_we = 1'b1;
    ext_addr = a;
    ext_wdata = d;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 8192; i++) begin
      sram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    sram_rdata = '0;
    cptra_rst_b = 1'b1;
    core_req = 1'b1;
    core_addr = 13'h5;
    ext_addr = '0;
    ext_wdata = '0;
    ext_we = 1'b0;
    ext_lock = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();
    idle();
    step();

    // Core idle: three buffered writes drain back-to-back.
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) wr(13'h10 + 13'(i), 64'hA0 + 64'(i));
      else ext_we = 1'b0;
      step();
      pat = {pat[8:0], last_we};
    end
    chk("buffered_we_pattern", 64'(pat[4:0]), 64'b01110);

    // Starvation relief after eight consecutive core wins.
    core_req = 1'b1;
    core_addr = 13'h100;
    wr(13'h20, 64'hDEAD_BEEF);
    step();
    ext_we = 1'b0;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      pat = {pat[8:0], last_gnt};
    end
    chk("starve_gnt_pattern", 64'(pat), 64'b1111111101);

    // Read-after-write hazard: the buffered write goes first.
    idle();
    wr(13'h40, 64'h1234_5678_9ABC_DEF0);
    step();
    ext_we = 1'b0;
    core_req = 1'b1;
    core_addr = 13'h40;
    step();
    chk("hazard_write_first", 64'(last_we), 64'd1);
    step();
    chk("hazard_then_gnt", 64'(last_gnt), 64'd1);
    core_req = 1'b0;
    chk("hazard_rdata", core_rdata, 64'h1234_5678_9ABC_DEF0);
    step();

    // Overflow: fifth back-to-back write is dropped while full forces a drain.
    core_req = 1'b1;
    core_addr = 13'h200;
    for (int i = 0; i < 5; i++) begin
      wr(13'h50 + 13'(i), 64'hF0 + 64'(i));
      step();
    end
    chk("overflow_full_on_5th", 64'(last_full), 64'd1);
    chk("overflow_drain", 64'(last_we), 64'd1);
    idle();
    step();
    chk("overflow_drop_err", 64'(ext_drop_err), 64'd1);
    for (int i = 0; i < 4; i++) step();

    // Random traffic on a narrow address range to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      core_req = $urandom_range(0, 9) < 6;
      core_addr = 13'($urandom_range(0, 7));
      ext_we = 1'($urandom_range(0, 1));
      ext_addr = 13'($urandom_range(0, 7));
      ext_wdata = {$urandom, $urandom};
      step();
    end

    // Reset mid-drain discards buffered writes.
    idle();
    do_reset();
    core_req = 1'b1;
    core_addr = 13'h300;
    for (int i = 0; i < 3; i++) begin
      wr(13'h70 + 13'(i), 64'h70 + 64'(i));
      step();
    end
    ext_we = 1'b0;
    do_reset();
    idle();
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      pat = {pat[8:0], last_we};
    end
    chk("post_reset_no_stale", 64'(pat), 64'd0);
    chk("post_reset_cs", 64'(sram_cs), 64'd0);

    // Lock with two entries buffered: they drain, later writes drop.
    core_req = 1'b1;
    core_addr = 13'h300;
    wr(13'h60, 64'h60);
    step();
    wr(13'h61, 64'h61);
    step();
    ext_we = 1'b0;
    ext_lock = 1'b1;
    step();
    idle();
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      pat = {pat[8:0], last_we};
    end
    chk("lock_drain_pattern", 64'(pat[2:0]), 64'b110);
    chk("lock_no_drop_yet", 64'(ext_drop_err), 64'd0);
    wr(13'h62, 64'h62);
    step();
    ext_we = 1'b0;
    step();
    chk("lock_drop_err", 64'(ext_drop_err), 64'd1);
    wr(13'h63, 64'h63);
    step();
    ext_we = 1'b0;
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      pat = {pat[8:0], last_we};
    end
    chk("lock_held", 64'(pat), 64'd0);

    // Fresh random traffic after reset clears the lock.
    idle();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      core_req = $urandom_range(0, 9) < 5;
      core_addr = 13'($urandom_range(0, 7));
      ext_we = 1'($urandom_range(0, 1));
      ext_addr = 13'($urandom_range(0, 7));
      ext_wdata = {$urandom, $urandom};
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/caliptra_imem_arb.md
CALIPTRA_IMEM_ARB -- requirements
Module: caliptra_imem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, giving the IMEM word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, giving the IMEM data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the number of external write buffer entries (power of 2, 2..16).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, giving the number of consecutive core wins after which a pending external write is forced through.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port cptra_rst_b, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port core_req, input, 1 bit: core fetch request.
REQ-008 SHALL have port core_addr, input, ADDR_W bits: core fetch address.
REQ-009 SHALL have port core_gnt, output, 1 bit: core request accepted this cycle.
REQ-010 SHALL have port core_rvalid, output, 1 bit: core read data valid.
REQ-011 SHALL have port core_rdata, output, DATA_W bits: core read data.
REQ-012 SHALL have ports ext_we (input, 1), ext_addr (input, ADDR_W) and ext_wdata (input, DATA_W): external loader write.
REQ-013 SHALL have port ext_full, output, 1 bit: write buffer full, so writes are not accepted.
REQ-014 SHALL have port ext_lock, input, 1 bit: firmware load complete, so further external writes are forbidden.
REQ-015 SHALL have port ext_drop_err, output, 1 bit: sticky flag, an external write was dropped.
REQ-016 SHALL have ports sram_cs, sram_we (outputs, 1), sram_addr (output, ADDR_W), sram_wdata (output, DATA_W) and sram_rdata (input, DATA_W): single-port IMEM SRAM with 1-cycle read latency.

Function
REQ-017 SHALL accept an external write when ext_we=1, ext_full=0 and the lock state is OPEN, enqueuing {addr, data} at that clock edge.
REQ-018 SHALL drop an external write when ext_we=1 and (ext_full=1 or the lock state is LOCKED), and SHALL set ext_drop_err at the next edge.
REQ-019 SHALL keep a lock FSM with states OPEN (reset state) and LOCKED; OPEN->LOCKED when ext_lock=1; LOCKED is held until reset; buffered entries continue to drain while LOCKED.
REQ-020 SHALL drive ext_full from the registered occupancy, with ext_full=1 exactly when count==FIFO_DEPTH.
REQ-021 SHALL select ext_win = fifo_nonempty AND (NOT core_req OR starve OR full OR hazard), combinationally.
REQ-022 SHALL assert hazard when core_addr equals the address of any valid FIFO entry, so the write completes before the read.
REQ-023 SHALL drive core_gnt = core_req AND NOT ext_win.
REQ-024 SHALL, when ext_win=1, drive sram_cs=1, sram_we=1, and sram_addr/sram_wdata from the FIFO head, and SHALL dequeue at that edge.
REQ-025 SHALL, when core_gnt=1, drive sram_cs=1, sram_we=0 and sram_addr=core_addr.
REQ-026 SHALL otherwise drive sram_cs=0 and sram_we=0, with sram_addr and sram_wdata at 0.
REQ-027 SHALL register core_rvalid as core_gnt delayed by 1 cycle, and SHALL drive core_rdata = sram_rdata (passthrough).
REQ-028 SHALL increment a starve counter when fifo_nonempty and core_gnt, saturating at STARVE_LIMIT, and SHALL clear it on any dequeue or when the FIFO is empty.
REQ-029 SHALL assert starve exactly when the counter equals STARVE_LIMIT.
REQ-030 SHALL handle a simultaneous enqueue and dequeue by leaving the count unchanged; the write and read pointers wrap modulo FIFO_DEPTH.
REQ-031 SHALL keep FIFO order: the oldest entry is always written first.

Reset
REQ-032 SHALL, on cptra_rst_b=0, asynchronously clear the FIFO pointers and count, the starve counter, core_rvalid and ext_drop_err, and set the FSM to OPEN.
REQ-033 SHALL discard buffered writes on a reset mid-operation, and SHALL drive all outputs to 0 during reset except core_rdata, which follows sram_rdata.

Structure
REQ-034 SHALL place the FIFO entry struct (addr, data) and the lock-state enum in caliptra_imem_arb_pkg.
REQ-035 SHALL implement the buffer as sub-module caliptra_imem_wr_fifo, which exposes per-entry valid and address for the hazard compare.

Verification
REQ-036 SHALL cover the buffered-write case: core idle, 3 ext writes (addr 0x10..0x12) -> 3 SRAM writes on consecutive cycles starting the cycle after the first accept, ext_full=0.
REQ-037 SHALL cover starvation: core_req held, 1 write buffered -> core_gnt=1 for 8 cycles, then core_gnt=0 for 1 cycle while the write drains, then core_gnt=1.
REQ-038 SHALL cover the hazard case: write addr 0x40 buffered, core_req addr 0x40 -> write first, then grant; core_rdata equals the written data 1 cycle after grant.
REQ-039 SHALL cover overflow: core_req held, 5 writes back-to-back -> 4 accepted, ext_full=1 on the 5th, ext_drop_err=1, and the full condition forces a drain.
REQ-040 SHALL cover lock: ext_lock pulsed with 2 entries buffered -> both entries drain, a later ext_we is dropped, ext_drop_err=1, and the FSM stays LOCKED.
REQ-041 SHALL cover reset mid-drain: cptra_rst_b low with 3 entries buffered -> after release, count=0, sram_cs=0 and no stale writes.
